hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter INIT_FLUSH_CYCLES, default 2, number of post-reset cycles during which the pipeline is held and flushed.
REQ-002 Parameter CNT_WIDTH, default 16, width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 PCSrc_E  input  1  taken branch or jump resolved in Execute.
REQ-006 ResultSrc_E_lsb  input  1  Execute instruction is a load.
REQ-007 RegWrite_M / RegWrite_W  input  1 each  register-write enables in Memory and Writeback.
REQ-008 Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W  input  5 each  register indices per stage.
REQ-009 cnt_clr  input  1  synchronous clear of both counters.
REQ-010 Stall_F, Stall_D  output  1 each  hold the PC and the Fetch/Decode register.
REQ-011 Flush_D, Flush_E  output  1 each  bubble the Fetch/Decode and Decode/Execute registers.
REQ-012 ForwardA_E, ForwardB_E  output  2 each  Execute operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-013 hz_state  output  2  current FSM state.
REQ-014 stall_cnt, flush_cnt  output  CNT_WIDTH each  saturating event counters.

Function
REQ-015 FSM states SHALL be encoded as INIT=00, RUN=01, STALL=10, REDIRECT=11.
REQ-016 The block SHALL compute lw_stall = ResultSrc_E_lsb & (Rd_E!=0) & (Rd_E==Rs1_D | Rd_E==Rs2_D) combinationally.
REQ-017 ForwardA_E SHALL be 10 if RegWrite_M & Rd_M!=0 & Rd_M==Rs1_E, else 01 if RegWrite_W & Rd_W!=0 & Rd_W==Rs1_E, else 00; the Memory match wins when both stages match.
REQ-018 ForwardB_E SHALL follow REQ-017 with Rs2_E in place of Rs1_E.
REQ-019 In INIT, outputs SHALL be Stall_F=1, Stall_D=0, Flush_D=1, Flush_E=1, ForwardA_E=ForwardB_E=00, independent of the other inputs.
REQ-020 INIT SHALL last exactly INIT_FLUSH_CYCLES cycles after rst_n deasserts, counted by an internal counter; the FSM then enters RUN. INIT_FLUSH_CYCLES=0 SHALL give RUN on the first edge.
REQ-021 Outside INIT, outputs SHALL be combinational with zero latency: Flush_D=PCSrc_E; Flush_E=PCSrc_E | lw_stall; Stall_F=Stall_D=lw_stall & ~PCSrc_E.
REQ-022 When PCSrc_E and lw_stall are both asserted, redirect SHALL take priority: both flushes asserted and both stalls deasserted.
REQ-023 Outside INIT, the next state SHALL be REDIRECT if PCSrc_E, else STALL if lw_stall, else RUN; the state reflects the previous cycle's classification.
REQ-024 stall_cnt SHALL increment on each edge where Stall_D=1 outside INIT; flush_cnt SHALL increment on each edge where Flush_D=1 outside INIT.
REQ-025 Counters SHALL saturate at all-ones and not wrap.
REQ-026 cnt_clr SHALL zero both counters on the next edge, overriding any same-cycle increment.
REQ-027 Register index 0 SHALL never cause forwarding or a stall.

Reset
REQ-028 rst_n low SHALL asynchronously force state=INIT, init counter=0, and stall_cnt=flush_cnt=0.
REQ-029 While rst_n is low, outputs SHALL hold the INIT values of REQ-019.
REQ-030 Reset asserted mid-STALL or mid-REDIRECT SHALL abort that state immediately; INIT SHALL restart with its full duration after release.

Verification
REQ-031 Release rst_n with default parameters -> Flush_D=Flush_E=Stall_F=1 for exactly 2 cycles, hz_state 00 then 01, counters 0.
REQ-032 RUN, ResultSrc_E_lsb=1, Rd_E=5, Rs2_D=5 -> Stall_F=Stall_D=Flush_E=1, Flush_D=0 same cycle; next hz_state=10; stall_cnt=1.
REQ-033 RegWrite_M=1, Rd_M=3; RegWrite_W=1, Rd_W=3; Rs1_E=3; Rs2_E=0 -> ForwardA_E=10, ForwardB_E=00; then RegWrite_M=0 -> ForwardA_E=01.
REQ-034 PCSrc_E=1 together with lw_stall condition -> Flush_D=Flush_E=1, Stall_F=Stall_D=0, next hz_state=11, flush_cnt+1, stall_cnt unchanged.
REQ-035 CNT_WIDTH=4, 20 consecutive redirects -> flush_cnt holds 15; cnt_clr with PCSrc_E=1 -> flush_cnt=0.
REQ-036 rst_n pulsed low during STALL -> outputs switch to INIT values asynchronously, counters 0, full 2-cycle INIT after release.

Source files
------------

// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit signal bundle: stage register indices and controls in,
// stall/flush/forward controls out.
interface hazard_if;
    logic       PCSrc_E;
    logic       ResultSrc_E_lsb;
    logic       RegWrite_M;
    logic       RegWrite_W;
    logic [4:0] Rs1_D;
    logic [4:0] Rs2_D;
    logic [4:0] Rs1_E;
    logic [4:0] Rs2_E;
    logic [4:0] Rd_E;
    logic [4:0] Rd_M;
    logic [4:0] Rd_W;
    logic       Stall_F;
    logic       Stall_D;
    logic       Flush_D;
    logic       Flush_E;
    logic [1:0] ForwardA_E;
    logic [1:0] ForwardB_E;

    modport master (
        output PCSrc_E, ResultSrc_E_lsb, RegWrite_M, RegWrite_W,
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        input  Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_E, ForwardB_E
    );

    modport slave (
        input  PCSrc_E, ResultSrc_E_lsb, RegWrite_M, RegWrite_W,
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        output Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_E, ForwardB_E
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: load-use stall, branch redirect flush, operand
// forwarding, a post-reset flush window and saturating stall/flush event counters.
module hazard_unit #(
    parameter int INIT_FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_if.slave              hz,
    input  logic                 cnt_clr,
    output logic [1:0]           hz_state,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);
    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_STALL    = 2'b10,
        ST_REDIRECT = 2'b11
    } state_t;

    localparam int INIT_W = (INIT_FLUSH_CYCLES > 1) ? $clog2(INIT_FLUSH_CYCLES) : 1;

    state_t               state_q, state_d;
    logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
    logic                 lw_stall;
    logic                 init_last;
    logic                 stall_f, stall_d, flush_d, flush_e;
    logic [1:0]           fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m, input logic [4:0] rd_m,
                                           input logic       wr_w, input logic [4:0] rd_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lw_stall = hz.ResultSrc_E_lsb && (hz.Rd_E != 5'd0) &&
                      ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));

    assign init_last = (int'(init_cnt_q) + 1) >= INIT_FLUSH_CYCLES;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        if (state_q == ST_INIT) begin
            // Hold the PC but bubble both front registers so garbage never retires.
            stall_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (init_last) begin
                state_d    = ST_RUN;
                init_cnt_d = '0;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end else begin
            flush_d = hz.PCSrc_E;
            flush_e = hz.PCSrc_E | lw_stall;
            stall_f = lw_stall & ~hz.PCSrc_E;
            stall_d = lw_stall & ~hz.PCSrc_E;
            fwd_a   = fwd_sel(hz.Rs1_E, hz.RegWrite_M, hz.Rd_M, hz.RegWrite_W, hz.Rd_W);
            fwd_b   = fwd_sel(hz.Rs2_E, hz.RegWrite_M, hz.Rd_M, hz.RegWrite_W, hz.Rd_W);
            if (hz.PCSrc_E)
                state_d = ST_REDIRECT;
            else if (lw_stall)
                state_d = ST_STALL;
            else
                state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Clear wins over a same-cycle event; counts stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (cnt_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q != ST_INIT) && stall_d && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if ((state_q != ST_INIT) && flush_d && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign hz.Stall_F    = stall_f;
    assign hz.Stall_D    = stall_d;
    assign hz.Flush_D    = flush_d;
    assign hz.Flush_E    = flush_e;
    assign hz.ForwardA_E = fwd_a;
    assign hz.ForwardB_E = fwd_b;
    assign hz_state      = state_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default instance plus a CNT_WIDTH=4,
// INIT_FLUSH_CYCLES=0 instance for saturation and zero-length init.
module tb_hazard_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr1 = 1'b0;
    logic        cnt_clr2 = 1'b0;
    logic [1:0]  hz_state1, hz_state2;
    logic [15:0] stall_cnt1, flush_cnt1;
    logic [3:0]  stall_cnt2, flush_cnt2;
    int          checks = 0;
    int          errors = 0;

    hazard_if if1 ();
    hazard_if if2 ();

    hazard_unit u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .hz       (if1),
        .cnt_clr  (cnt_clr1),
        .hz_state (hz_state1),
        .stall_cnt(stall_cnt1),
        .flush_cnt(flush_cnt1)
    );

    hazard_unit #(.INIT_FLUSH_CYCLES(0), .CNT_WIDTH(4)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .hz       (if2),
        .cnt_clr  (cnt_clr2),
        .hz_state (hz_state2),
        .stall_cnt(stall_cnt2),
        .flush_cnt(flush_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic quiet1();
        if1.PCSrc_E = 0; if1.ResultSrc_E_lsb = 0; if1.RegWrite_M = 0; if1.RegWrite_W = 0;
        if1.Rs1_D = 0; if1.Rs2_D = 0; if1.Rs1_E = 0; if1.Rs2_E = 0;
        if1.Rd_E = 0; if1.Rd_M = 0; if1.Rd_W = 0;
    endtask

    task automatic quiet2();
        if2.PCSrc_E = 0; if2.ResultSrc_E_lsb = 0; if2.RegWrite_M = 0; if2.RegWrite_W = 0;
        if2.Rs1_D = 0; if2.Rs2_D = 0; if2.Rs1_E = 0; if2.Rs2_E = 0;
        if2.Rd_E = 0; if2.Rd_M = 0; if2.Rd_W = 0;
    endtask

    // Stall_F, Stall_D, Flush_D, Flush_E packed into one nibble.
    function automatic logic [3:0] ctl1();
        return {if1.Stall_F, if1.Stall_D, if1.Flush_D, if1.Flush_E};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_window(input string tag);
        tick();
        check({tag, "_e1_state"}, 32'(hz_state1), 32'd0);
        check({tag, "_e1_ctl"}, 32'(ctl1()), 32'b1011);
        check({tag, "_e1_state2"}, 32'(hz_state2), 32'd1);
        tick();
        check({tag, "_e2_state"}, 32'(hz_state1), 32'd1);
        check({tag, "_e2_ctl"}, 32'(ctl1()), 32'b0000);
        check({tag, "_cnts"}, {stall_cnt1, flush_cnt1}, 32'd0);
    endtask

    initial begin
        quiet1();
        quiet2();
        // Load-use condition present during reset must not leak through.
        if1.ResultSrc_E_lsb = 1; if1.Rd_E = 5; if1.Rs2_D = 5; if1.PCSrc_E = 1;
        if1.RegWrite_M = 1; if1.Rd_M = 3; if1.Rs1_E = 3;
        #3;
        check("rst_ctl", 32'(ctl1()), 32'b1011);
        check("rst_fwd", {if1.ForwardA_E, if1.ForwardB_E}, 32'd0);
        check("rst_state", 32'(hz_state1), 32'd0);
        check("rst_cnts", {stall_cnt1, flush_cnt1}, 32'd0);
        quiet1();
        @(negedge clk);
        rst_n = 1'b1;
        init_window("init");

        // Load-use on Rs2_D
        if1.ResultSrc_E_lsb = 1; if1.Rd_E = 5; if1.Rs2_D = 5;
        #2;
        check("lw_ctl", 32'(ctl1()), 32'b1101);
        tick();
        check("lw_state", 32'(hz_state1), 32'd2);
        check("lw_stall_cnt", 32'(stall_cnt1), 32'd1);
        check("lw_flush_cnt", 32'(flush_cnt1), 32'd0);

        // x0 destination never stalls
        quiet1();
        if1.ResultSrc_E_lsb = 1; if1.Rd_E = 0; if1.Rs1_D = 0; if1.Rs2_D = 0;
        #2;
        check("x0_ctl", 32'(ctl1()), 32'b0000);
        tick();
        check("x0_state", 32'(hz_state1), 32'd1);

        // Load-use on Rs1_D
        quiet1();
        if1.ResultSrc_E_lsb = 1; if1.Rd_E = 7; if1.Rs1_D = 7; if1.Rs2_D = 1;
        #2;
        check("lw1_ctl", 32'(ctl1()), 32'b1101);
        tick();
        check("lw1_stall_cnt", 32'(stall_cnt1), 32'd2);

        // Forwarding priority and x0 exclusion
        quiet1();
        if1.RegWrite_M = 1; if1.Rd_M = 3; if1.RegWrite_W = 1; if1.Rd_W = 3;
        if1.Rs1_E = 3; if1.Rs2_E = 0;
        #2;
        check("fwd_mem", {if1.ForwardA_E, if1.ForwardB_E}, 32'b1000);
        if1.RegWrite_M = 0;
        #1;
        check("fwd_wb", {if1.ForwardA_E, if1.ForwardB_E}, 32'b0100);
        if1.Rs2_E = 3; if1.RegWrite_M = 1; if1.Rd_M = 9; if1.Rs1_E = 9;
        #1;
        check("fwd_mix", {if1.ForwardA_E, if1.ForwardB_E}, 32'b1001);
        if1.Rd_M = 0; if1.Rs1_E = 0; if1.Rd_W = 0; if1.Rs2_E = 0;
        #1;
        check("fwd_x0", {if1.ForwardA_E, if1.ForwardB_E}, 32'b0000);
        tick();
        check("fwd_state", 32'(hz_state1), 32'd1);

        // Redirect overrides load-use
        quiet1();
        if1.PCSrc_E = 1; if1.ResultSrc_E_lsb = 1; if1.Rd_E = 5; if1.Rs2_D = 5;
        #2;
        check("redir_ctl", 32'(ctl1()), 32'b0011);
        tick();
        check("redir_state", 32'(hz_state1), 32'd3);
        check("redir_flush_cnt", 32'(flush_cnt1), 32'd1);
        check("redir_stall_cnt", 32'(stall_cnt1), 32'd2);
        quiet1();
        if1.PCSrc_E = 1;
        tick();
        check("redir2_flush_cnt", 32'(flush_cnt1), 32'd2);
        quiet1();
        tick();
        check("run_state", 32'(hz_state1), 32'd1);

        // Asynchronous reset in the middle of STALL
        if1.ResultSrc_E_lsb = 1; if1.Rd_E = 4; if1.Rs1_D = 4;
        tick();
        check("mid_state", 32'(hz_state1), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(hz_state1), 32'd0);
        check("arst_ctl", 32'(ctl1()), 32'b1011);
        check("arst_cnts", {stall_cnt1, flush_cnt1}, 32'd0);
        quiet1();
        @(negedge clk);
        rst_n = 1'b1;
        init_window("rinit");

        // Saturation on the 4-bit instance
        if2.PCSrc_E = 1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_flush_cnt", 32'(flush_cnt2), 32'd15);
        check("sat_state", 32'(hz_state2), 32'd3);
        check("sat_stall_cnt", 32'(stall_cnt2), 32'd0);
        cnt_clr2 = 1;
        tick();
        check("clr_flush_cnt", 32'(flush_cnt2), 32'd0);
        cnt_clr2 = 0;
        tick();
        check("post_clr_flush_cnt", 32'(flush_cnt2), 32'd1);
        quiet2();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
